serial_adder: RTL and testbench

- Bit-serial N-bit adder built around a single full-adder cell and a carry flip-flop.
- Two operands and a carry-in are loaded in parallel, then added one bit per clock, LSB first.
- The parallel sum and carry-out are presented with a valid/ready handshake.
- This is the sequential stage that drives the one-bit full adder: it feeds the cell's a/b/c inputs and registers its s/cout outputs.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_fa_cell.sv | 14 +
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must index 0..w-1; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder used as the arithmetic core of
// serial_adder. Distinct name so it can live next to the library full adder.
module serial_adder_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are loaded in parallel, summed LSB
// first through a single full-adder cell plus a carry flop, and the result
// is offered on a valid/ready handshake.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf_out,
`endif
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int                CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             co;

    serial_adder_fa_cell u_fa_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the LSB lands at bit 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_next = s;
        end else begin : g_wn
            assign sum_next = {s, sum_sr[WIDTH-1:1]};
        end
    endgenerate

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    // FSM, shift datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            sum_sr     <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            sum_out    <= '0;
            cout_out   <= 1'b0;
            done_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_out    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next;
                    carry  <= co;
                    if (cnt == LAST) begin
                        state      <= DONE;
                        sum_out    <= sum_next;
                        cout_out   <= co;
                        done_valid <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB on the last step
                        ovf_out    <= carry ^ co;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed plan vectors,
// backpressure, mid-operation reset, ignored inputs while busy and a
// randomized run against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;
    localparam int TMO = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         done_valid;
    logic         done_ready;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin         (cin),
        .sum_out     (sum_out),
        .cout_out    (cout_out),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf_out     (ovf_out),
`endif
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned addition, one bit wider than the operands.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Reference: signed overflow when equal-sign operands give a different-sign sum.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c);
        logic [W:0] r;
        r = ref_sum(a, b, c);
        return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    // Present operands for exactly one accepting edge (block must be idle).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    // Count edges after acceptance until done_valid rises, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done_valid && cyc < TMO);
    endtask

    // Pulse done_ready for one edge.
    task automatic accept;
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sum_out !== '0 || cout_out !== 1'b0 || done_valid !== 1'b0 ||
            busy !== 1'b0 || start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: sum=%h cout=%b dv=%b busy=%b sr=%b, want 00 0 0 0 1",
                     sum_out, cout_out, done_valid, busy, start_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [W-1:0] va [3] = '{8'h00, 8'hFF, 8'h3C};
        logic [W-1:0] vb [3] = '{8'h00, 8'h01, 8'h0F};
        logic         vc [3] = '{1'b0, 1'b0, 1'b0};
        logic [W-1:0] es [3] = '{8'h00, 8'h00, 8'h4B};
        logic         ec [3] = '{1'b0, 1'b1, 1'b0};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            launch(va[i], vb[i], vc[i]);
            wait_done(cyc);
            n_checks++;
            if (done_valid !== 1'b1 || cyc != W) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: dv=%b after %0d edges, want 1 after %0d",
                         i, done_valid, cyc, W);
            end
            n_checks++;
            if (sum_out !== es[i] || cout_out !== ec[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got %b_%h want %b_%h",
                         i, cout_out, sum_out, ec[i], es[i]);
            end
            accept();
        end
    endtask

    task automatic test_ignore_while_busy;
        int cyc;
        int bad;
        launch(8'hA5, 8'h5A, 1'b1);
        // hammer the start port with different operands while shifting
        a_in = 8'h11; b_in = 8'h22; cin = 1'b0; start_valid = 1'b1;
        bad = 0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (start_ready !== 1'b0 || busy !== 1'b1) bad++;
            a_in = W'($urandom); b_in = W'($urandom);
        end while (!done_valid && cyc < TMO);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy_start_ready: %0d cycles with start_ready/busy wrong, want 0", bad);
        end
        n_checks++;
        if (done_valid !== 1'b1 || cyc != W || sum_out !== 8'h00 || cout_out !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_ignore: dv=%b cyc=%0d got %b_%h want 1 %0d 1_00",
                     done_valid, cyc, cout_out, sum_out, W);
        end
        // still offering operands: DONE must not restart either
        @(posedge clk);
        #1;
        n_checks++;
        if (start_ready !== 1'b0 || done_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL done_start_ready: sr=%b dv=%b want 0 1", start_ready, done_valid);
        end
        start_valid = 1'b0;
        accept();
    endtask

    task automatic test_backpressure;
        int cyc;
        int bad;
        launch(8'h3C, 8'h0F, 1'b0);
        wait_done(cyc);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (done_valid !== 1'b1 || sum_out !== 8'h4B || cout_out !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        n_checks++;
        if (bad != 0 || cyc != W) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d unstable cycles, cyc=%0d, want 0 and %0d",
                     bad, cyc, W);
        end
        accept();
        n_checks++;
        if (done_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0 || sum_out !== 8'h4B) begin
            n_fail++;
            $display("FAIL backpressure_release: dv=%b sr=%b busy=%b sum=%h want 0 1 0 4b",
                     done_valid, start_ready, busy, sum_out);
        end
        // done_ready while idle must be harmless
        done_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        done_ready = 1'b0;
        n_checks++;
        if (done_valid !== 1'b0 || start_ready !== 1'b1 || sum_out !== 8'h4B) begin
            n_fail++;
            $display("FAIL idle_done_ready: dv=%b sr=%b sum=%h want 0 1 4b",
                     done_valid, start_ready, sum_out);
        end
    endtask

    task automatic test_reset_mid_shift;
        int cyc;
        int pulses;
        launch(8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;           // fourth shift edge sees reset
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (done_valid !== 1'b0 || sum_out !== '0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_shift: dv=%b sum=%h sr=%b busy=%b want 0 00 1 0",
                     done_valid, sum_out, start_ready, busy);
        end
        pulses = 0;
        repeat (2 * W) begin
            @(posedge clk);
            #1;
            if (done_valid) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_discard: %0d done_valid cycles, want 0", pulses);
        end
        launch(8'h01, 8'h01, 1'b0);
        wait_done(cyc);
        n_checks++;
        if (done_valid !== 1'b1 || sum_out !== 8'h02 || cout_out !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_op: dv=%b got %b_%h want 1 0_02", done_valid, cout_out, sum_out);
        end
        accept();
        // reset while holding a result in DONE
        launch(8'h80, 8'h80, 1'b1);
        wait_done(cyc);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (done_valid !== 1'b0 || sum_out !== '0 || cout_out !== 1'b0 || start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_done: dv=%b got %b_%h sr=%b want 0 0_00 1",
                     done_valid, cout_out, sum_out, start_ready);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W:0]   r;
        int cyc;
        int hold;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            if (i == 0) begin a = '1; b = '1; c = 1'b1; end
            r = ref_sum(a, b, c);
            launch(a, b, c);
            wait_done(cyc);
            hold = $urandom_range(0, 3);
            repeat (hold) @(posedge clk);
            #1;
            n_checks++;
            if (done_valid !== 1'b1 || cyc != W || {cout_out, sum_out} !== r) begin
                n_fail++;
                $display("FAIL random[%0d]: %h+%h+%b dv=%b cyc=%0d got %b_%h want %b_%h",
                         i, a, b, c, done_valid, cyc, cout_out, sum_out, r[W], r[W-1:0]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            n_checks++;
            if (ovf_out !== ref_ovf(a, b, c)) begin
                n_fail++;
                $display("FAIL random_ovf[%0d]: %h+%h+%b got %b want %b",
                         i, a, b, c, ovf_out, ref_ovf(a, b, c));
            end
`endif
            accept();
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf;
        int cyc;
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(cyc);
        n_checks++;
        if (sum_out !== 8'h80 || cout_out !== 1'b0 || ovf_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_pos: got %b_%h ovf=%b want 0_80 ovf=1", cout_out, sum_out, ovf_out);
        end
        accept();
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(cyc);
        n_checks++;
        if (sum_out !== 8'h00 || cout_out !== 1'b1 || ovf_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_wrap: got %b_%h ovf=%b want 1_00 ovf=0", cout_out, sum_out, ovf_out);
        end
        accept();
    endtask
`endif

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
        a_in = '0; b_in = '0; cin = 1'b0;
        test_reset();
        test_directed();
        test_ignore_while_busy();
        test_backpressure();
        test_reset_mid_shift();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
